// File: rtl/mod_arith_pkg.sv
// Shared residue-arithmetic definitions for the modular add/subtract channels.
package mod_arith_pkg;

  localparam int DEFAULT_DATA_WIDTH = 18;
  localparam int DEFAULT_MODULUS    = 177147;

  // Working width of the fix-up helper; covers any DATA_WIDTH up to 31.
  localparam int FIX_W = 34;

  typedef logic [DEFAULT_DATA_WIDTH-1:0] residue_t;

  typedef struct packed {
    logic [DEFAULT_DATA_WIDTH+1:0] diff;
    logic                          range_err;
  } sub_item_t;

  // Fold a two's-complement difference back into [0, m): add m once when negative.
  function automatic logic [FIX_W-1:0] mod_sub_fix(input logic [FIX_W-1:0] diff,
                                                   input logic [FIX_W-1:0] m);
    logic [FIX_W-1:0] fixed;
    if (diff[FIX_W-1]) begin
      fixed = diff + m;
    end else begin
      fixed = diff;
    end
    return fixed;
  endfunction

endpackage

// File: rtl/mod_pipe_slice.sv
// Generic valid/ready register slice; one entry, full throughput, registered outputs.
module mod_pipe_slice #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;
  logic             advance_s;

  // The slice may load whenever it is empty or its content leaves this cycle.
  assign advance_s = !valid_r || out_ready;

  // Hold the entry under back-pressure, otherwise take the upstream item (or a bubble).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_r <= 1'b0;
      data_r  <= '0;
    end else if (advance_s) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

  assign in_ready  = advance_s;
  assign out_valid = valid_r;
  assign out_data  = data_r;

endmodule

// File: rtl/mod_sub_borrow_pipe.sv
// Two-stage modular subtractor with borrow: result = (A - B - bin) mod MODULUS.
module mod_sub_borrow_pipe
  import mod_arith_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int MODULUS    = DEFAULT_MODULUS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic                  bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  bout,
  output logic                  range_err
);

  // Stage 1 payload: signed difference (DATA_WIDTH+2 bits) plus range flag.
  localparam int S1_W = DATA_WIDTH + 3;
  // Stage 2 payload: reduced residue, borrow-out, range flag.
  localparam int S2_W = DATA_WIDTH + 2;
  // MODULUS may equal 2^DATA_WIDTH, so compare operands one bit wider.
  localparam logic [DATA_WIDTH:0] MOD_EXT = (DATA_WIDTH+1)'(MODULUS);

  logic [DATA_WIDTH+1:0] diff_s;
  logic                  range_s;
  logic [S1_W-1:0]       s1_in_s;
  logic [S1_W-1:0]       s1_out_s;
  logic                  s1_valid_s;
  logic                  s2_ready_s;
  logic [DATA_WIDTH+1:0] s1_diff_s;
  logic                  s1_range_s;
  logic [FIX_W-1:0]      fix_s;
  logic [FIX_W-1:DATA_WIDTH] fix_unused_s;
  logic                  bout_s;
  logic [S2_W-1:0]       s2_in_s;
  logic [S2_W-1:0]       s2_out_s;

  // Stage 1 arithmetic: raw two's-complement difference and operand range check.
  always_comb begin
    diff_s  = {2'b00, A} - {2'b00, B} - {{(DATA_WIDTH+1){1'b0}}, bin};
    range_s = ({1'b0, A} >= MOD_EXT) || ({1'b0, B} >= MOD_EXT);
    s1_in_s = {diff_s, range_s};
  end

  mod_pipe_slice #(.WIDTH(S1_W)) u_stage1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (s1_in_s),
    .out_valid (s1_valid_s),
    .out_ready (s2_ready_s),
    .out_data  (s1_out_s)
  );

  // Stage 2 arithmetic: add the modulus back when the difference went negative.
  always_comb begin
    s1_diff_s    = s1_out_s[S1_W-1:1];
    s1_range_s   = s1_out_s[0];
    bout_s       = s1_diff_s[DATA_WIDTH+1];
    fix_s        = mod_sub_fix(FIX_W'($signed(s1_diff_s)), FIX_W'(MODULUS));
    fix_unused_s = fix_s[FIX_W-1:DATA_WIDTH];
    s2_in_s      = {fix_s[DATA_WIDTH-1:0], bout_s, s1_range_s};
  end

  mod_pipe_slice #(.WIDTH(S2_W)) u_stage2 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (s1_valid_s),
    .in_ready  (s2_ready_s),
    .in_data   (s2_in_s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (s2_out_s)
  );

  assign result    = s2_out_s[S2_W-1:2];
  assign bout      = s2_out_s[1];
  assign range_err = s2_out_s[0];

endmodule
